// File: rtl/sphere_anim_ctrl.sv
// Per-frame sphere motion sequencer: on the first blanking line it steps x (wall bounce)
// and y (gravity/floor bounce), then commits position and frame parity while blanked.
module sphere_anim_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned RADIUS   = 48,
  parameter int unsigned X_MIN    = 48,
  parameter int unsigned X_MAX    = 591,
  parameter int unsigned Y_MIN    = 48,
  parameter int unsigned FLOOR_Y  = 432,
  parameter int unsigned CX_INIT  = 320,
  parameter int unsigned CY_INIT  = 100,
  parameter int unsigned VX_SPEED = 2,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned VY_MAX   = 24,
  parameter int unsigned BOUNCE_V = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] h_count,
  input  logic [9:0]  v_count,
  input  logic        pause,
  input  logic        restart,
  output logic [10:0] sphere_cx,
  output logic [9:0]  sphere_cy,
  output logic [7:0]  radius,
  output logic        frame,
  output logic        busy,
  output logic        update_done
);

  // The sphere must fit entirely inside the visible line at both walls.
  if (X_MAX + RADIUS > H_ACTIVE || X_MIN < RADIUS) begin : g_bad_x_range
    $error("sphere_anim_ctrl: x wall limits do not fit the active line");
  end

  typedef enum logic [1:0] {StIdle, StUpdX, StUpdY, StCommit} state_e;

  localparam logic signed [11:0] XMax    = 12'(X_MAX);
  localparam logic signed [11:0] XMin    = 12'(X_MIN);
  localparam logic signed [10:0] YFloor  = 11'(FLOOR_Y);
  localparam logic signed [10:0] YMin    = 11'(Y_MIN);
  localparam logic signed [7:0]  VxPos   = 8'(VX_SPEED);
  localparam logic signed [7:0]  VxNeg   = 8'(-VX_SPEED);
  localparam logic signed [7:0]  VyBnc   = 8'(-BOUNCE_V);
  localparam logic signed [8:0]  VyMax9  = 9'(VY_MAX);
  localparam logic signed [8:0]  Grav9   = 9'(GRAVITY);

  state_e             state_q, state_d;
  logic [10:0]        wx_q, wx_d, cx_q, cx_d;
  logic [9:0]         wy_q, wy_d, cy_q, cy_d;
  logic signed [7:0]  vx_q, vx_d, vy_q, vy_d;
  logic               frame_q, frame_d, done_q, done_d, pend_q, pend_d;

  logic               trig;
  logic signed [11:0] nx;
  logic signed [8:0]  vsum;
  logic signed [7:0]  vg;
  logic signed [10:0] ny;

  assign trig = (h_count == 11'd0) && (v_count == 10'(V_ACTIVE));

  // One extra sign bit on every sum so a step past a wall never wraps.
  assign nx   = $signed({1'b0, wx_q}) + $signed({{4{vx_q[7]}}, vx_q});
  assign vsum = $signed({vy_q[7], vy_q}) + Grav9;
  assign vg   = (vsum > VyMax9) ? VyMax9[7:0] : vsum[7:0];
  assign ny   = $signed({1'b0, wy_q}) + $signed({{3{vg[7]}}, vg});

  always_comb begin
    state_d = state_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    pend_d  = pend_q;

    unique case (state_q)
      StIdle: begin
        if (trig) state_d = StUpdX;
      end
      StUpdX: begin
        state_d = StUpdY;
        if (pend_q) begin
          wx_d = 11'(CX_INIT);
          vx_d = VxPos;
        end else if (!pause) begin
          if (nx >= XMax) begin
            wx_d = XMax[10:0];
            vx_d = VxNeg;
          end else if (nx <= XMin) begin
            wx_d = XMin[10:0];
            vx_d = VxPos;
          end else begin
            wx_d = nx[10:0];
          end
        end
      end
      StUpdY: begin
        state_d = StCommit;
        if (pend_q) begin
          wy_d = 10'(CY_INIT);
          vy_d = 8'sd0;
        end else if (!pause) begin
          if (ny >= YFloor) begin
            wy_d = YFloor[9:0];
            vy_d = VyBnc;
          end else if (ny <= YMin) begin
            wy_d = YMin[9:0];
            vy_d = 8'sd0;
          end else begin
            wy_d = ny[9:0];
            vy_d = vg;
          end
        end
      end
      StCommit: begin
        state_d = StIdle;
        cx_d    = wx_q;
        cy_d    = wy_q;
        frame_d = ~frame_q;
        done_d  = 1'b1;
        pend_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    // A pulse coinciding with the commit is kept for the next frame.
    if (restart) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wx_q    <= 11'(CX_INIT);
      wy_q    <= 10'(CY_INIT);
      vx_q    <= VxPos;
      vy_q    <= 8'sd0;
      cx_q    <= 11'(CX_INIT);
      cy_q    <= 10'(CY_INIT);
      frame_q <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  assign sphere_cx   = cx_q;
  assign sphere_cy   = cy_q;
  assign radius      = 8'(RADIUS);
  assign frame       = frame_q;
  assign busy        = (state_q != StIdle);
  assign update_done = done_q;

endmodule
